instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the core's immediate decode: packs instruction fields into 32-bit RV32 load (I), store (S)
//  and branch (B) words, then writes them one by one into instruction memory at consecutive word addresses.
//  Sits between a test or boot sequencer and the IMEM write port. It preloads programs for the single-cycle CPU.
// PARAMETERS
//  BASE_ADDR  32'h0  byte address of the first word written
//  DEPTH      64     maximum words written before full; power of two, >=2
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  clr          in   1   sync clear: address/count/full/err state back to reset values
//  in_valid     in   1   field bundle valid
//  in_ready     out  1   block can accept a bundle this cycle
//  in_fmt       in   2   00=I-load(0000011) 01=S(0100011) 11=B(1100011) 10=illegal
//  in_rd        in   5   destination register (I only)
//  in_rs1       in   5   source register 1
//  in_rs2       in   5   source register 2 (S/B only)
//  in_funct3    in   3   funct3 field, passed through
//  in_imm       in   32  signed immediate, byte offset
//  imem_we      out  1   IMEM write strobe, one cycle per word
//  imem_addr    out  32  IMEM byte address
//  imem_wdata   out  32  encoded instruction word
//  word_cnt     out  $clog2(DEPTH)+1  words written so far
//  full         out  1   DEPTH words written
//  err          out  1   one-cycle pulse: bundle rejected
//  err_cnt      out  8   rejected bundles, saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//   word_cnt=0, full=0, err=0, err_cnt=0. Reset mid-write aborts immediately: no partial write survives.
//  States: IDLE (in_ready=1), WRITE (in_ready=0, imem_we=1), FULL (in_ready=0).
//  Handshake: accept when in_valid&&in_ready. No new accept in WRITE, so throughput is 1 word per 2 cycles.
//  On accept: word is encoded combinationally and registered into imem_wdata.
//   Legal bundle: go to WRITE. Rejected bundle: err=1 next cycle, err_cnt+1, stay IDLE, no write.
//  WRITE (exactly 1 cycle): imem_we=1 at the current imem_addr. Next cycle: imem_addr+=4, word_cnt+=1.
//   Go to FULL if word_cnt reaches DEPTH, else go to IDLE.
//  FULL: holds until clr or reset. in_valid is ignored and err does not pulse.
//  clr: takes priority over everything except reset; in any state, next cycle = reset values.
//   A write in progress in WRITE completes its strobe cycle, but its count is discarded.
//  Encoding (imm=in_imm, fields in place):
//   I: {imm[11:0],rs1,funct3,rd,7'b0000011}
//   S: {imm[11:5],rs2,rs1,funct3,imm[4:0],7'b0100011}
//   B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],7'b1100011}
//  in_fmt=10: always rejected.
//  imem_addr wraps modulo 2^32, which is unreachable for legal DEPTH/BASE_ADDR.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: an immediate must be representable, otherwise the bundle is rejected.
//   I/S: in_imm[31:11] all equal.
//   B: in_imm[31:12] all equal and in_imm[0]==0.
//  IMM_RANGE_CHECK_EN undefined: no immediate check; out-of-range bits are silently truncated.
//   Only fmt=10 raises err.
// TESTING
//  fmt=00 rd=5 rs1=2 f3=010 imm=8 -> imem_we at addr BASE, wdata=32'h00812283; word_cnt=1.
//  fmt=01 rs2=6 rs1=2 f3=010 imm=-4 -> wdata=32'hFE612E23 at BASE+4.
//  fmt=11 rs1=1 rs2=2 f3=000 imm=-8 -> wdata=32'hFE208CE3. fmt=10 -> err pulse, err_cnt=1, no write.
//  fmt=00 imm=2048 -> with _EN: err, no write. Without _EN: wdata=32'h80012283 (rd=5 rs1=2 f3=010).
//  DEPTH=4, send 5 legal bundles -> 4 writes; full=1, in_ready=0; 5th bundle not accepted.
//   Then clr -> imem_addr=BASE, word_cnt=0, full=0.
//  rst_n low during WRITE -> imem_we=0 in the same cycle, imem_addr=BASE.
//   After release, the next bundle writes at BASE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs RV32 I-load/S/B fields and writes them to IMEM at consecutive words
// Optional feature: IMM_RANGE_CHECK_EN rejects bundles whose immediate does not fit the format.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_fmt,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic [31:0]                in_imm,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH):0]     word_cnt,
    output logic                       full,
    output logic                       err,
    output logic [7:0]                 err_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, FULL_ST} state_t;
    state_t state, state_nxt;

    logic [31:0] enc;
    logic        imm_ok;
    logic        legal;
    logic        accept;

    always_comb begin
        enc = '0;
        case (in_fmt)
            2'b00:   enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            2'b01:   enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            2'b11:   enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            default: enc = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Sign-extension bits must all match; branch offsets must also be halfword aligned.
    always_comb begin
        imm_ok = 1'b1;
        if (in_fmt == 2'b11)
            imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
        else
            imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    end
`else
    logic unused_imm;
    assign unused_imm = ^in_imm[31:13];
    assign imm_ok     = 1'b1;
`endif

    assign legal    = (in_fmt != 2'b10) && imm_ok;
    assign in_ready = (state == IDLE) && !clr;
    assign accept   = in_valid && in_ready;
    assign imem_we  = (state == WRITE);
    assign full     = (state == FULL_ST);

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && legal) state_nxt = WRITE;
                WRITE:   state_nxt = (word_cnt == CW'(DEPTH - 1)) ? FULL_ST : IDLE;
                FULL_ST: state_nxt = FULL_ST;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            word_cnt   <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            // A strobe already in WRITE still completes this cycle; its count is dropped here.
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            word_cnt   <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (accept && legal)
                imem_wdata <= enc;
            if (state == WRITE) begin
                imem_addr <= imem_addr + 32'd4;
                word_cnt  <= word_cnt + CW'(1);
            end
        end
    end
endmodule
